// File: rtl/tag_serializer_pkg.sv
// Shared constants and types for the tag record serializer.
// A FIFO entry is {lost_flag, record}, sent as six bytes MSB first.
package tag_serializer_pkg;

    localparam int unsigned REC_W         = 47;
    localparam int unsigned WORD_W        = 48;
    localparam int unsigned BYTES_PER_REC = 6;
    localparam logic [15:0] LOST_MAX      = 16'hFFFF;

    typedef enum logic {IDLE, SEND} ser_state_e;

endpackage

// File: rtl/record_fifo.sv
// Synchronous FIFO of tag record entries with first-word-fall-through read data.
// The pointers carry one extra bit so that full and empty can be told apart.
module record_fifo
    import tag_serializer_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WIDTH      = WORD_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q;
    logic [DEPTH_LOG2:0] rd_ptr_q;
    logic                do_wr;
    logic                do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + (DEPTH_LOG2 + 1)'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + (DEPTH_LOG2 + 1)'(1);
            end
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = count[DEPTH_LOG2];
    assign empty   = (count == '0);

endmodule

// File: rtl/tag_record_serializer.sv
// Buffers tag records from the event tagger and streams each one as six bytes.
// Records arriving while the FIFO is full are dropped, counted and flagged in-band.
module tag_record_serializer #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned REC_W      = tag_serializer_pkg::REC_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  data_rdy,
    input  logic [REC_W-1:0]      data,
    output logic                  byte_valid,
    output logic [7:0]            byte_out,
    input  logic                  byte_ready,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic [15:0]           lost_count
);

    import tag_serializer_pkg::*;

    localparam int unsigned ENTRY_W  = REC_W + 1;
    localparam logic [2:0]  LAST_IDX = 3'(BYTES_PER_REC - 1);

    ser_state_e         state_q;
    logic [ENTRY_W-1:0] shift_q;
    logic [2:0]         idx_q;
    logic               lost_pending_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_rd_data;
    logic               push;
    logic               pop;
    logic               last_accept;

    // Full is judged on the pre-edge count, so a same-edge pop never rescues a write.
    assign push        = data_rdy && !fifo_full;
    assign last_accept = (state_q == SEND) && byte_ready && (idx_q == LAST_IDX);
    assign pop         = !fifo_empty && ((state_q == IDLE) || last_accept);

    record_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (push),
        .wr_data ({lost_pending_q, data}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign byte_out = shift_q[ENTRY_W-1 -: 8];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            idx_q          <= '0;
            byte_valid     <= 1'b0;
            lost_pending_q <= 1'b0;
            lost_count     <= '0;
        end else begin
            if (data_rdy) begin
                if (fifo_full) begin
                    lost_pending_q <= 1'b1;
                    if (lost_count != LOST_MAX) begin
                        lost_count <= lost_count + 16'd1;
                    end
                end else begin
                    lost_pending_q <= 1'b0;
                end
            end

            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        shift_q    <= fifo_rd_data;
                        idx_q      <= '0;
                        byte_valid <= 1'b1;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (byte_ready) begin
                        if (idx_q != LAST_IDX) begin
                            shift_q <= {shift_q[ENTRY_W-9:0], 8'h00};
                            idx_q   <= idx_q + 3'd1;
                        end else if (!fifo_empty) begin
                            // Back-to-back records: reload without an idle bubble.
                            shift_q <= fifo_rd_data;
                            idx_q   <= '0;
                        end else begin
                            byte_valid <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
